// File: rtl/router_pkg.sv
// Shared router definitions: reader FSM states and default entry geometry,
// common to the FIFO and the packet reader.
package router_pkg;

  localparam int unsigned DEF_WIDTH     = 11;
  localparam int unsigned DEF_UWIDTH    = 8;
  localparam int unsigned DEF_PTR_IN_SZ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    POP  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fifo_packet_reader.sv
// Reads one FIFO entry (WIDTH units of UWIDTH bits) and streams it as a
// packet on a valid/ready byte port with sop/eop markers, then retires the
// entry with a single rinc pulse.
// Optional feature macro: FIFO_PKT_LEN_EN -- unit 0 bits [PTR_IN_SZ-1:0]
// carry the packet length (header included); 0 or >WIDTH means WIDTH.
module fifo_packet_reader #(
  parameter int unsigned WIDTH     = router_pkg::DEF_WIDTH,
  parameter int unsigned UWIDTH    = router_pkg::DEF_UWIDTH,
  parameter int unsigned PTR_IN_SZ = router_pkg::DEF_PTR_IN_SZ
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rempty,
  input  logic [UWIDTH-1:0]    rdata,
  output logic                 rinc,
  output logic [PTR_IN_SZ-1:0] raddr_in,
  output logic [UWIDTH-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sop,
  output logic                 out_eop
);
  import router_pkg::*;

  localparam logic [PTR_IN_SZ-1:0] LAST_FULL = PTR_IN_SZ'(WIDTH - 1);

  rd_state_t             state, state_next;
  logic [PTR_IN_SZ-1:0]  idx, idx_next, idx_inc;
  logic [UWIDTH-1:0]     data_next;
  logic                  valid_next, sop_next, eop_next;
  logic                  fire;
  logic [PTR_IN_SZ-1:0]  last;      // index of the final byte of the current packet
  logic [PTR_IN_SZ-1:0]  acc_last;  // final-byte index for the entry being accepted

`ifdef FIFO_PKT_LEN_EN
  localparam int unsigned LEN_W = PTR_IN_SZ + 1;

  logic [LEN_W-1:0] len, len_next, hdr_len;

  // Decode the header length, folding illegal values onto a full entry
  always_comb begin
    hdr_len = LEN_W'(rdata[PTR_IN_SZ-1:0]);
    if (hdr_len == '0 || hdr_len > LEN_W'(WIDTH)) begin
      hdr_len = LEN_W'(WIDTH);
    end
  end

  assign last     = PTR_IN_SZ'(len - LEN_W'(1));
  assign acc_last = PTR_IN_SZ'(hdr_len - LEN_W'(1));

  // Packet length register, loaded when an entry is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len <= LEN_W'(WIDTH);
    end else begin
      len <= len_next;
    end
  end
`else
  assign last     = LAST_FULL;
  assign acc_last = LAST_FULL;
`endif

  assign fire    = out_valid & out_ready;
  assign idx_inc = idx + PTR_IN_SZ'(1);

  // Next-state, datapath next values and the combinational FIFO-side outputs
  always_comb begin
    state_next = state;
    idx_next   = idx;
    data_next  = out_data;
    valid_next = out_valid;
    sop_next   = out_sop;
    eop_next   = out_eop;
`ifdef FIFO_PKT_LEN_EN
    len_next   = len;
`endif
    raddr_in   = '0;
    rinc       = 1'b0;
    case (state)
      IDLE: begin
        if (!rempty) begin
          data_next  = rdata;
          idx_next   = '0;
          valid_next = 1'b1;
          sop_next   = 1'b1;
          eop_next   = (acc_last == '0);
`ifdef FIFO_PKT_LEN_EN
          len_next   = hdr_len;
`endif
          state_next = SEND;
        end
      end
      SEND: begin
        // Look ahead one unit on fire so the next byte is ready at the edge
        raddr_in = idx;
        if (fire) begin
          if (idx != last) begin
            raddr_in  = idx_inc;
            idx_next  = idx_inc;
            data_next = rdata;
            sop_next  = 1'b0;
            eop_next  = (idx_inc == last);
          end else begin
            valid_next = 1'b0;
            eop_next   = 1'b0;
            state_next = POP;
          end
        end
      end
      POP: begin
        raddr_in   = idx;
        rinc       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, index and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      out_data  <= data_next;
      out_valid <= valid_next;
      out_sop   <= sop_next;
      out_eop   <= eop_next;
    end
  end

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Self-checking bench for fifo_packet_reader with a small behavioural FIFO.
// Honors FIFO_PKT_LEN_EN when the design is built with it.
module tb_fifo_packet_reader;

  localparam int unsigned WIDTH     = 11;
  localparam int unsigned UWIDTH    = 8;
  localparam int unsigned PTR_IN_SZ = 4;
  localparam int unsigned DEPTH     = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rempty;
  logic [UWIDTH-1:0]    rdata;
  logic                 rinc;
  logic [PTR_IN_SZ-1:0] raddr_in;
  logic [UWIDTH-1:0]    out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sop;
  logic                 out_eop;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fifo_packet_reader #(
    .WIDTH(WIDTH),
    .UWIDTH(UWIDTH),
    .PTR_IN_SZ(PTR_IN_SZ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rempty(rempty),
    .rdata(rdata),
    .rinc(rinc),
    .raddr_in(raddr_in),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sop(out_sop),
    .out_eop(out_eop)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: whole entries, combinational unit read
  logic [UWIDTH-1:0] mem [DEPTH][WIDTH];
  int unsigned head  = 0;
  int unsigned count = 0;

  assign rempty = (count == 0);

  always_comb begin
    rdata = '0;
    if (int'(raddr_in) < int'(WIDTH)) rdata = mem[head][raddr_in];
  end

  task automatic push(input logic [7:0] base);
    for (int unsigned k = 0; k < WIDTH; k++) mem[(head + count) % DEPTH][k] = base + 8'(k);
    count++;
  endtask

  task automatic pop();
    if (count > 0) begin
      head  = (head + 1) % DEPTH;
      count--;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  base;       // byte 0 of packet p is base + 16*p, byte i adds i
    int unsigned npkts;
    logic [15:0] ready_pat;  // out_ready per cycle, repeating
    int unsigned exp_bytes;  // bytes per packet
    int unsigned exp_rinc;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int unsigned p = 0, i = 0, cyc = 0, rinc_seen = 0;
    int unsigned last_fire = 0, rinc_cyc = 0, sop_cyc = 0;
    bit          done = 1'b0, first = 1'b1;
    logic [7:0]  exp_b;
    for (int unsigned k = 0; k < v.npkts; k++) push(v.base + 8'(k * 16));
    while (!done && cyc < 600) begin
      @(negedge clk);
      cyc++;
      out_ready = v.ready_pat[cyc % 16];
      #1;
      if (rinc) begin
        rinc_seen++;
        check("rinc_after_eop", cyc, last_fire + 1);
        rinc_cyc = cyc;
        pop();
        if (rinc_seen >= v.npkts) done = 1'b1;
      end
      if (out_valid) begin
        exp_b = v.base + 8'(p * 16) + 8'(i);
        check("data", out_data, exp_b);
        check("sop", out_sop, (i == 0));
        check("eop", out_eop, (i == v.exp_bytes - 1));
        if (first) begin
          sop_cyc = cyc;
          if (p > 0) check("gap", cyc - rinc_cyc, 2);
          first = 1'b0;
        end
        if (out_ready && i != v.exp_bytes - 1) check("raddr", raddr_in, i + 1);
        else check("raddr", raddr_in, i);
        if (out_ready) begin
          if (i == v.exp_bytes - 1) begin
            if (v.ready_pat == 16'hFFFF) check("burst_len", cyc - sop_cyc, v.exp_bytes - 1);
            last_fire = cyc;
            p++;
            i = 0;
            first = 1'b1;
          end else begin
            i++;
          end
        end
      end
    end
    check("timeout", done, 1'b1);
    check("pkts", p, v.npkts);
    check("rinc_cnt", rinc_seen, v.exp_rinc);
    for (int unsigned t = 0; t < 3; t++) begin
      @(negedge clk);
      #1;
      check("tail_rinc", rinc, 1'b0);
      check("tail_valid", out_valid, 1'b0);
    end
    out_ready = 1'b0;
  endtask

  vec_t vecs [$];
  bit   got5;
  bit   drained;

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_sop", out_sop, 1'b0);
    check("rst_eop", out_eop, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_rinc", rinc, 1'b0);
    check("rst_raddr", raddr_in, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

`ifdef FIFO_PKT_LEN_EN
    vecs.push_back('{base: 8'h04, npkts: 2, ready_pat: 16'hFFFF, exp_bytes: 4,  exp_rinc: 2});
    vecs.push_back('{base: 8'h00, npkts: 1, ready_pat: 16'hFFFF, exp_bytes: 11, exp_rinc: 1});
    vecs.push_back('{base: 8'h0F, npkts: 1, ready_pat: 16'hFFFF, exp_bytes: 11, exp_rinc: 1});
    vecs.push_back('{base: 8'h01, npkts: 2, ready_pat: 16'h9999, exp_bytes: 1,  exp_rinc: 2});
    vecs.push_back('{base: 8'h0B, npkts: 1, ready_pat: 16'h5A5A, exp_bytes: 11, exp_rinc: 1});
    vecs.push_back('{base: 8'h0C, npkts: 1, ready_pat: 16'hFFFF, exp_bytes: 11, exp_rinc: 1});
`endif
    vecs.push_back('{base: 8'h10, npkts: 1, ready_pat: 16'hFFFF, exp_bytes: 11, exp_rinc: 1});
    vecs.push_back('{base: 8'h20, npkts: 1, ready_pat: 16'h9999, exp_bytes: 11, exp_rinc: 1});
    vecs.push_back('{base: 8'h30, npkts: 2, ready_pat: 16'hFFFF, exp_bytes: 11, exp_rinc: 2});
    vecs.push_back('{base: 8'h50, npkts: 3, ready_pat: 16'h5A5A, exp_bytes: 11, exp_rinc: 3});

    foreach (vecs[n]) run_vec(vecs[n]);

    // Reset in the middle of a packet
    push(8'h40);
    out_ready = 1'b1;
    got5 = 1'b0;
    for (int unsigned c = 0; c < 40 && !got5; c++) begin
      @(negedge clk);
      #1;
      if (rinc) pop();
      if (out_valid && out_data == 8'h45) got5 = 1'b1;
    end
    check("reach_byte5", got5, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 8'h00);
    check("mid_rst_sop", out_sop, 1'b0);
    check("mid_rst_eop", out_eop, 1'b0);
    check("mid_rst_rinc", rinc, 1'b0);
    count = 0;
    head  = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("mid_rst_hold_rinc", rinc, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_raddr", raddr_in, 4'h0);
    check("post_rst_rinc", rinc, 1'b0);
    push(8'h60);
    @(negedge clk);
    #1;
    check("latency_valid", out_valid, 1'b1);
    check("latency_sop", out_sop, 1'b1);
    check("latency_data", out_data, 8'h60);
    drained = 1'b0;
    for (int unsigned c = 0; c < 40 && !drained; c++) begin
      @(negedge clk);
      #1;
      if (rinc) begin
        pop();
        drained = 1'b1;
      end
    end
    check("post_rst_drain", drained, 1'b1);

    // Empty FIFO for 100 cycles
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int unsigned c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      check("idle_valid", out_valid, 1'b0);
      check("idle_rinc", rinc, 1'b0);
      check("idle_raddr", raddr_in, 4'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
